// File: rtl/fpga_cfg_pkg.sv
// Shared types and constants for the FPGA configuration loader.
// Holds the loader state encoding and the host byte width.
package fpga_cfg_pkg;

   localparam int unsigned CFG_BYTE_W = 8;

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StLoadClb  = 2'd1,
      StLoadConn = 2'd2,
      StDone     = 2'd3
   } cfg_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/cfg_serializer.sv
// Byte-to-bit serializer: shifts one byte LSB first, two clk cycles per bit
// (scan_clk low with data driven, then scan_clk high with data held).
module cfg_serializer
   import fpga_cfg_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  flush,
   input  logic [CFG_BYTE_W-1:0] data,
   output logic                  empty,
   output logic                  bit_done,
   output logic                  scan_clk,
   output logic                  scan_data
);

   localparam int unsigned    IdxW    = $clog2(CFG_BYTE_W);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(CFG_BYTE_W - 1);

   logic                  active_q;
   logic [CFG_BYTE_W-1:0] shreg_q;
   logic [IdxW-1:0]       idx_q;
   logic [IdxW-1:0]       idx_nxt;
   logic                  phase_q;
   logic                  data_q;

   assign idx_nxt = idx_q + IdxW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_q <= 1'b0;
         shreg_q  <= '0;
         idx_q    <= '0;
         phase_q  <= 1'b0;
         data_q   <= 1'b0;
      end else if (flush) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         phase_q  <= 1'b0;
         data_q   <= 1'b0;
      end else if (load) begin
         active_q <= 1'b1;
         shreg_q  <= data;
         idx_q    <= '0;
         phase_q  <= 1'b0;
         data_q   <= data[0];
      end else if (active_q) begin
         if (!phase_q) begin
            phase_q <= 1'b1;
         end else if (idx_q == LastIdx) begin
            active_q <= 1'b0;
            phase_q  <= 1'b0;
            data_q   <= 1'b0;
         end else begin
            idx_q   <= idx_nxt;
            phase_q <= 1'b0;
            data_q  <= shreg_q[idx_nxt];
         end
      end
   end

   // The final high phase already counts as empty so the next byte can be
   // accepted without a bubble between bytes.
   assign empty     = ~active_q | (phase_q & (idx_q == LastIdx));
   assign bit_done  = active_q & phase_q;
   assign scan_clk  = phase_q;
   assign scan_data = data_q;

endmodule

// File: rtl/fpga_cfg_loader.sv
// Configuration loader: streams host bytes into the CLB scan chain and then
// the connection scan chain, with abort, sticky error and done status.
module fpga_cfg_loader
   import fpga_cfg_pkg::*;
#(
   parameter int unsigned CLB_BITS  = 2048,
   parameter int unsigned CONN_BITS = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [CFG_BYTE_W-1:0] cfg_data,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   output logic                  scan_clk,
   output logic                  clb_scan_in,
   output logic                  clb_scan_en,
   output logic                  conn_scan_in,
   output logic                  conn_scan_en,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int unsigned CntW = $clog2(max_u(CLB_BITS, CONN_BITS) + 1);

   cfg_state_e      state_q;
   logic [CntW-1:0] cnt_q;
   logic            busy_q;
   logic            done_q;
   logic            err_q;
   logic            clb_en_q;
   logic            conn_en_q;

   logic ser_load;
   logic ser_flush;
   logic ser_empty;
   logic ser_bit_done;
   logic ser_clk;
   logic ser_data;
   logic last_bit;

   assign last_bit  = ser_bit_done & (cnt_q == CntW'(1));
   // No byte may follow the very last connection bit, otherwise it would
   // shift while already in DONE.
   assign cfg_ready = busy_q & ser_empty & ~((state_q == StLoadConn) & last_bit);
   assign ser_load  = cfg_valid & cfg_ready;
   assign ser_flush = abort & busy_q;

   cfg_serializer u_serializer (
      .clk       (clk),
      .reset     (reset),
      .load      (ser_load),
      .flush     (ser_flush),
      .data      (cfg_data),
      .empty     (ser_empty),
      .bit_done  (ser_bit_done),
      .scan_clk  (ser_clk),
      .scan_data (ser_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         clb_en_q  <= 1'b0;
         conn_en_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q   <= StLoadClb;
                  cnt_q     <= CntW'(CLB_BITS);
                  busy_q    <= 1'b1;
                  done_q    <= 1'b0;
                  err_q     <= 1'b0;
                  clb_en_q  <= 1'b1;
                  conn_en_q <= 1'b0;
               end
            end
            StLoadClb: begin
               if (abort) begin
                  state_q   <= StIdle;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  clb_en_q  <= 1'b0;
                  conn_en_q <= 1'b0;
               end else if (ser_bit_done) begin
                  if (last_bit) begin
                     state_q   <= StLoadConn;
                     cnt_q     <= CntW'(CONN_BITS);
                     clb_en_q  <= 1'b0;
                     conn_en_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
            end
            StLoadConn: begin
               if (abort) begin
                  state_q   <= StIdle;
                  cnt_q     <= '0;
                  busy_q    <= 1'b0;
                  err_q     <= 1'b1;
                  clb_en_q  <= 1'b0;
                  conn_en_q <= 1'b0;
               end else if (ser_bit_done) begin
                  if (last_bit) begin
                     state_q   <= StDone;
                     cnt_q     <= '0;
                     busy_q    <= 1'b0;
                     done_q    <= 1'b1;
                     conn_en_q <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
            end
            default: begin
               state_q   <= StIdle;
               cnt_q     <= '0;
               busy_q    <= 1'b0;
               done_q    <= 1'b0;
               clb_en_q  <= 1'b0;
               conn_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign scan_clk     = ser_clk;
   assign clb_scan_in  = ser_data & clb_en_q;
   assign conn_scan_in = ser_data & conn_en_q;
   assign clb_scan_en  = clb_en_q;
   assign conn_scan_en = conn_en_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign err          = err_q;

endmodule
